// File: rtl/key_serial_loader.sv
// key_serial_loader
// Receives a key as a serial bit stream (LSB first) under a valid/ready
// handshake, optionally checks a trailing even-parity bit, and commits the
// key atomically to a registered parallel bus that drives keyIn_0_*.
module key_serial_loader #(
  parameter int unsigned KEY_WIDTH = 16,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  output logic                 ser_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_loaded,
  output logic                 load_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PAR,
    S_COMMIT,
    S_ERR
  } state_t;

  state_t                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic [KEY_WIDTH-1:0]   shadow_q, shadow_d;
  logic [KEY_WIDTH-1:0]   key_q,    key_d;
  logic                   loaded_q, loaded_d;
  logic                   err_q,    err_d;
  logic                   ready_q,  ready_d;
  logic                   busy_q,   busy_d;

  logic xfer;
  logic last_bit;
  logic parity_ok;

  assign xfer      = ser_valid && ready_q;
  assign last_bit  = (cnt_q == CNT_W'(KEY_WIDTH - 1));
  assign parity_ok = ~((^shadow_q) ^ ser_data);

  assign ser_ready  = ready_q;
  assign key_out    = key_q;
  assign key_loaded = loaded_q;
  assign load_err   = err_q;
  assign busy       = busy_q;

  // State and datapath registers; reset clears everything including the committed key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      key_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath updates; key_q changes only in COMMIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    loaded_d = loaded_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SHIFT;
          cnt_d    = '0;
          shadow_d = '0;
          err_d    = 1'b0;
        end
      end

      S_SHIFT: begin
        if (xfer) begin
          for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              shadow_d[i] = ser_data;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_d = PARITY_EN ? S_PAR : S_COMMIT;
          end
        end
      end

      S_PAR: begin
        if (xfer) begin
          state_d = parity_ok ? S_COMMIT : S_ERR;
        end
      end

      S_COMMIT: begin
        key_d    = shadow_q;
        loaded_d = 1'b1;
        state_d  = S_IDLE;
      end

      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and status flags registered from state.
  // ser_ready tracks the upcoming state so it is high for the first bit after start;
  // busy lags state by one edge so it falls two edges after the final transfer.
  always_comb begin
    ready_d = (state_d == S_SHIFT) || (state_d == S_PAR);
    busy_d  = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_key_serial_loader.sv
// Directed, table-driven bench for key_serial_loader: a parity-enabled
// instance exercised through a vector table plus hand sequences, and a
// parity-disabled instance exercised by a short hand sequence.
module tb_key_serial_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start,  ser_valid,  ser_data;
  logic        ser_ready,  key_loaded,  load_err,  busy;
  logic [15:0] key_out;
  logic        start2, ser_valid2, ser_data2;
  logic        ser_ready2, key_loaded2, load_err2, busy2;
  logic [15:0] key_out2;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] model_key    = '0;
  logic        model_loaded = 1'b0;

  always #5 clk = ~clk;

  key_serial_loader #(.KEY_WIDTH(16), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready), .key_out(key_out), .key_loaded(key_loaded),
    .load_err(load_err), .busy(busy)
  );

  key_serial_loader #(.KEY_WIDTH(16), .PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst(rst), .start(start2), .ser_valid(ser_valid2), .ser_data(ser_data2),
    .ser_ready(ser_ready2), .key_out(key_out2), .key_loaded(key_loaded2),
    .load_err(load_err2), .busy(busy2)
  );

  typedef struct {
    bit          do_rst;
    logic [15:0] key;
    bit          par;
    bit          gap;
    int          start_at;
    logic [15:0] exp_key;
    bit          exp_loaded;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_key    = '0;
    model_loaded = 1'b0;
  endtask

  // Start a load, stream 16 key bits plus parity, then check the
  // commit/error timeline at E, E+1 and E+2 (E = final transfer edge).
  task automatic run_vec(input vec_t v);
    logic [15:0] k;
    int idx;
    int cyc;
    bit xf;
    k = v.key;
    if (v.do_rst) pulse_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 17 && cyc < 100) begin
      ser_valid = !(v.gap && (cyc % 2 == 1));
      ser_data  = (idx < 16) ? k[idx] : v.par;
      start     = (v.start_at >= 0 && idx == v.start_at);
      xf = ser_valid && ser_ready;
      @(posedge clk); #1;
      if (xf) idx++;
      cyc++;
    end
    start     = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    chk("transfers", idx, 17);
    chk("cycles_used", cyc, v.gap ? 33 : 17);
    chk("key_hold_at_E", key_out, model_key);
    chk("busy_at_E", busy, 1);
    chk("ready_at_E", ser_ready, 0);
    @(posedge clk); #1;
    chk("key_out", key_out, v.exp_key);
    chk("key_loaded", key_loaded, v.exp_loaded);
    chk("load_err", load_err, v.exp_err);
    chk("busy_at_E1", busy, 1);
    @(posedge clk); #1;
    chk("busy_at_E2", busy, 0);
    model_key    = v.exp_key;
    model_loaded = v.exp_loaded;
  endtask

  initial begin
    vec_t v;
    logic [15:0] k2;
    int idx;
    int cyc;
    bit xf;

    //        rst   key       par   gap   start_at exp_key   ld    err
    vecs[0] = '{1'b1, 16'hA5C3, 1'b0, 1'b0, -1,      16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 16'hA5C3, 1'b1, 1'b0, -1,      16'h0000, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 16'h1234, 1'b1, 1'b0, -1,      16'h1234, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'hFFFF, 1'b0, 1'b1, -1,      16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h00FF, 1'b1, 1'b0, -1,      16'hFFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h0001, 1'b1, 1'b0, 5,       16'h0001, 1'b1, 1'b0};

    rst = 1'b1;
    start = 1'b0;  ser_valid = 1'b0;  ser_data = 1'b0;
    start2 = 1'b0; ser_valid2 = 1'b0; ser_data2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    chk("rst_key_out", key_out, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ser_ready, 0);
    chk("rst_np_outputs", {key_out2, key_loaded2, load_err2, busy2, ser_ready2}, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Reset after 7 accepted bits aborts the load and clears the committed key.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 7 && cyc < 50) begin
      ser_valid = 1'b1;
      ser_data  = 1'b1;
      xf = ser_valid && ser_ready;
      @(posedge clk); #1;
      if (xf) idx++;
      cyc++;
    end
    chk("pre_rst_transfers", idx, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    model_key    = '0;
    model_loaded = 1'b0;
    chk("midrst_key_out", key_out, 0);
    chk("midrst_key_loaded", key_loaded, 0);
    chk("midrst_load_err", load_err, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ser_ready, 0);
    @(posedge clk); #1;
    chk("midrst_idle_busy", busy, 0);
    v = '{1'b0, 16'h00FF, 1'b0, 1'b0, -1, 16'h00FF, 1'b1, 1'b0};
    run_vec(v);

    // start together with rst: reset wins and the block stays idle.
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_start_ready", ser_ready, 0);
    chk("rst_start_busy", busy, 0);
    chk("rst_start_key", key_out, 0);

    // Parity-disabled build: 16 bits only, never ready for a 17th.
    k2 = 16'h8001;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 50) begin
      ser_valid2 = 1'b1;
      ser_data2  = k2[idx];
      xf = ser_valid2 && ser_ready2;
      @(posedge clk); #1;
      if (xf) idx++;
      cyc++;
    end
    chk("np_transfers", idx, 16);
    chk("np_ready_at_E", ser_ready2, 0);
    chk("np_key_hold_at_E", key_out2, 0);
    ser_data2 = 1'b1;
    @(posedge clk); #1;
    chk("np_key_out", key_out2, 16'h8001);
    chk("np_key_loaded", key_loaded2, 1);
    chk("np_load_err", load_err2, 0);
    chk("np_ready_E1", ser_ready2, 0);
    @(posedge clk); #1;
    chk("np_busy_E2", busy2, 0);
    for (int i = 0; i < 3; i++) begin
      chk("np_no_17th_ready", ser_ready2, 0);
      @(posedge clk); #1;
    end
    chk("np_key_stable", key_out2, 16'h8001);
    ser_valid2 = 1'b0;
    ser_data2  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
